// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester arbiter in front of the single-port SPRAM data memory
//
// Purpose:
//   Shares one 16K x 16 SPRAM between the CPU data port (primary) and a
//   debug/loader port (secondary). One access is granted per cycle, registered
//   into an issue stage that drives the SPRAM, and read data is routed back to
//   its owner two cycles after acceptance. A CPU burst limit bounds how long a
//   waiting debug request can be starved.
//
// Ports:
//   clock, reset                      system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             CPU request, held until not stalled
//   cpu_stall                         CPU request not accepted this cycle
//   cpu_rdata, cpu_rvalid             CPU read return (rdata is 0 when not valid)
//   dbg_req/we/addr/wdata             debug request, held until dbg_ack
//   dbg_ack                           debug request accepted this cycle
//   dbg_rdata, dbg_rvalid             debug read return (rdata is 0 when not valid)
//   ram_addr/wdata/we/maskwren        SPRAM ADDRESS/DATAIN/WREN/MASKWREN
//   ram_rdata                         SPRAM DATAOUT
module spram_arbiter #(
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_CPU_BURST = 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_rvalid,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic [3:0]            ram_maskwren,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_CPU_BURST);
    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_DBG = 1'b1;

    logic                  cpu_win;
    logic                  dbg_win;

    logic [7:0]            burst_cnt_q,   burst_cnt_d;
    logic                  issue_valid_q, issue_valid_d;
    logic                  issue_owner_q, issue_owner_d;
    logic                  issue_we_q,    issue_we_d;
    logic [ADDR_WIDTH-1:0] issue_addr_q,  issue_addr_d;
    logic [DATA_WIDTH-1:0] issue_wdata_q, issue_wdata_d;
    logic                  rd_valid_q,    rd_valid_d;
    logic                  rd_owner_q,    rd_owner_d;

    // CPU has priority until it has taken BURST_MAX grants in a row while
    // debug was waiting; then debug takes exactly one slot.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (!reset) begin
            if (cpu_req && (!dbg_req || (burst_cnt_q < BURST_MAX))) begin
                cpu_win = 1'b1;
            end else if (dbg_req) begin
                dbg_win = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_win & ~reset;
    assign dbg_ack   = dbg_win;

    always_comb begin
        // The counter only measures starvation of a debug request that is
        // actually waiting, so it restarts whenever debug is idle or served.
        burst_cnt_d = burst_cnt_q;
        if (!dbg_req || dbg_win) begin
            burst_cnt_d = '0;
        end else if (cpu_win && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end

        // Address and data hold on idle cycles so the SPRAM pins stay quiet.
        issue_valid_d = cpu_win | dbg_win;
        issue_owner_d = issue_owner_q;
        issue_we_d    = issue_we_q;
        issue_addr_d  = issue_addr_q;
        issue_wdata_d = issue_wdata_q;
        if (cpu_win) begin
            issue_owner_d = OWNER_CPU;
            issue_we_d    = cpu_we;
            issue_addr_d  = cpu_addr;
            issue_wdata_d = cpu_wdata;
        end else if (dbg_win) begin
            issue_owner_d = OWNER_DBG;
            issue_we_d    = dbg_we;
            issue_addr_d  = dbg_addr;
            issue_wdata_d = dbg_wdata;
        end

        // SPRAM DATAOUT is registered, so the read presented this cycle
        // returns one cycle later; track its owner alongside it.
        rd_valid_d = issue_valid_q & ~issue_we_q;
        rd_owner_d = issue_owner_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            burst_cnt_q   <= '0;
            issue_valid_q <= 1'b0;
            issue_owner_q <= OWNER_CPU;
            issue_we_q    <= 1'b0;
            issue_addr_q  <= '0;
            issue_wdata_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_owner_q    <= OWNER_CPU;
        end else begin
            burst_cnt_q   <= burst_cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_owner_q <= issue_owner_d;
            issue_we_q    <= issue_we_d;
            issue_addr_q  <= issue_addr_d;
            issue_wdata_q <= issue_wdata_d;
            rd_valid_q    <= rd_valid_d;
            rd_owner_q    <= rd_owner_d;
        end
    end

    assign ram_addr     = issue_addr_q;
    assign ram_wdata    = issue_wdata_q;
    assign ram_we       = issue_valid_q & issue_we_q;
    assign ram_maskwren = {4{ram_we}};

    assign cpu_rvalid = rd_valid_q & (rd_owner_q == OWNER_CPU);
    assign dbg_rvalid = rd_valid_q & (rd_owner_q == OWNER_DBG);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - scoreboard bench for spram_arbiter with directed and random traffic
module tb_spram_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 16;
    localparam int MAXB = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_we;
    logic [3:0]    ram_maskwren;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CPU_BURST(MAXB)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_maskwren(ram_maskwren), .ram_rdata(ram_rdata)
    );

    // SPRAM behaviour: registered read, write on WREN.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
    end

    typedef struct packed {
        logic          vld;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        logic          owner;   // 0 = cpu, 1 = dbg
        logic          known;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    // Reference model: contents as seen in grant order, pending reads, and
    // the number of consecutive CPU grants taken while debug waited.
    logic [DW-1:0] shadow [int];
    exp_t          sbq [$];
    int            streak = 0;
    op_t           cop, dop;
    logic          obs_ack, obs_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic accept(input logic owner, input op_t op, input int c);
        exp_t e;
        if (op.we) begin
            shadow[int'(op.addr)] = op.wdata;
        end else begin
            e.owner = owner;
            e.known = shadow.exists(int'(op.addr));
            e.data  = e.known ? shadow[int'(op.addr)] : '0;
            e.due   = c + 2;
            sbq.push_back(e);
        end
    endtask

    // One clock cycle: present held requests, check acceptance against the
    // model at the falling edge, then advance the model.
    task automatic do_cycle();
        logic cw, dw, rst_now;
        int   c;
        cpu_req = cop.vld; cpu_we = cop.we; cpu_addr = cop.addr; cpu_wdata = cop.wdata;
        dbg_req = dop.vld; dbg_we = dop.we; dbg_addr = dop.addr; dbg_wdata = dop.wdata;
        @(negedge clock);
        c       = cyc;
        rst_now = reset;
        cw = !reset && cop.vld && (!dop.vld || streak < MAXB);
        dw = !reset && dop.vld && !cw;
        obs_ack   = dbg_ack;
        obs_stall = cpu_stall;
        check("cpu_stall", 32'(cpu_stall), 32'(!reset && cop.vld && !cw));
        check("dbg_ack", 32'(dbg_ack), 32'(dw));
        if (!reset) check("burst_cnt", 32'(dut.burst_cnt_q), 32'(streak));
        if (cw) accept(1'b0, cop, c);
        if (dw) accept(1'b1, dop, c);
        if (reset || !dop.vld || dw) streak = 0;
        else if (cw)                 streak = (streak + 1 > MAXB) ? MAXB : streak + 1;
        if (cw) cop.vld = 1'b0;
        if (dw) dop.vld = 1'b0;
        @(posedge clock);
        if (rst_now) begin
            // Reads still in the pipe when reset is sampled never return.
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].due > c) sbq.delete(i);
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
        check({tag, "_dbg_ack"}, 32'(dbg_ack), 32'd0);
        check({tag, "_rvalid"}, 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        check({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_ram_we"}, 32'({ram_we, ram_maskwren}), 32'd0);
        check({tag, "_burst_cnt"}, 32'(dut.burst_cnt_q), 32'd0);
    endtask

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.vld = 1'b1; o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 9) == 0) ? AW'(14'h3FFF) : AW'($urandom_range(0, 15));
    endfunction

    // Monitor: pops the scoreboard whenever read data is presented.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (!cpu_rvalid) check("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
            if (!dbg_rvalid) check("dbg_rdata_idle", 32'(dbg_rdata), 32'd0);
            if (cpu_rvalid || dbg_rvalid) begin
                check("rvalid_onehot", 32'(cpu_rvalid & dbg_rvalid), 32'd0);
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rvalid_cycle", 32'(cyc), 32'(e.due));
                    check("rvalid_owner", 32'(dbg_rvalid), 32'(e.owner));
                    if (e.known)
                        check("rdata", 32'(e.owner ? dbg_rdata : cpu_rdata), 32'(e.data));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("missing_rvalid", 32'(0), 32'(1));
            end
        end
    end

    initial begin
        int first_dbg;
        cop = '0;
        dop = '0;

        // Reset state
        reset = 1'b1;
        do_cycle();
        check_all_zero("reset");
        do_cycle();
        mon_en = 1'b1;
        reset  = 1'b0;
        do_cycle();

        // 1: CPU-only write then read
        cop = mk(1'b1, 14'h0123, 16'hBEEF); do_cycle();
        cop = mk(1'b0, 14'h0123, 16'h0000); do_cycle();
        repeat (3) do_cycle();

        // 2: debug-only read of a preloaded top address
        dop = mk(1'b1, 14'h3FFF, 16'h1234); do_cycle();
        dop = mk(1'b0, 14'h3FFF, 16'h0000); do_cycle();
        check("t2_dbg_ack", 32'(obs_ack), 32'd1);
        repeat (3) do_cycle();

        // 3: sustained contention, debug must win exactly after MAXB CPU grants
        first_dbg = -1;
        for (int i = 0; i < 24; i++) begin
            if (!cop.vld) cop = mk(1'b0, rnd_addr(), 16'h0);
            if (!dop.vld) dop = mk(1'b0, rnd_addr(), 16'h0);
            do_cycle();
            if (obs_ack && first_dbg < 0) begin
                first_dbg = i;
                check("t3_stall_on_dbg", 32'(obs_stall), 32'd1);
            end
        end
        check("t3_first_dbg_slot", 32'(first_dbg), 32'(MAXB));
        cop = '0; dop = '0;
        repeat (3) do_cycle();

        // 4: back-to-back interleaved reads
        cop = mk(1'b1, 14'h0A, 16'hAAAA); do_cycle();
        dop = mk(1'b1, 14'h0B, 16'hBBBB); do_cycle();
        cop = mk(1'b1, 14'h0C, 16'hCCCC); do_cycle();
        cop = mk(1'b0, 14'h0A, 16'h0); do_cycle();
        dop = mk(1'b0, 14'h0B, 16'h0); do_cycle();
        cop = mk(1'b0, 14'h0C, 16'h0); do_cycle();
        repeat (3) do_cycle();

        // 5: debug write then immediate CPU read of the same address
        dop = mk(1'b1, 14'h0010, 16'h5555); do_cycle();
        cop = mk(1'b0, 14'h0010, 16'h0); do_cycle();
        repeat (3) do_cycle();

        // 6: reset while a CPU read is in flight, request held across reset
        cop = mk(1'b0, 14'h0123, 16'h0); do_cycle();
        cop = mk(1'b0, 14'h0010, 16'h0);
        reset = 1'b1; do_cycle();
        check_all_zero("t6");
        do_cycle();
        reset = 1'b0; do_cycle();
        check("t6_regrant", 32'(obs_stall), 32'd0);
        repeat (3) do_cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if (!cop.vld && $urandom_range(0, 2) != 0)
                cop = mk(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom));
            if (!dop.vld && $urandom_range(0, 2) == 0)
                dop = mk(1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom));
            reset = ($urandom_range(0, 149) == 0);
            do_cycle();
        end
        reset = 1'b0;
        cop = '0; dop = '0;

        for (int i = 0; i < 10 && sbq.size() > 0; i++) do_cycle();
        do_cycle();
        check("drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares the single 16K x 16 SPRAM data memory between two requesters: the rj32 CPU data port (primary) and a debug/loader port (secondary).
- Sits between the CPU/debug logic and the SB_SPRAM256KA instance in the top level.
- Registers one winning access per cycle and routes read data back to its owner with a fixed latency.
- Bounds debug-port starvation with a CPU burst limit.

Parameters:
- ADDR_WIDTH, 14, word address width for all ports.
- DATA_WIDTH, 16, data width for all ports.
- MAX_CPU_BURST, 8, number of consecutive CPU grants allowed while a debug request waits. After that many grants, debug wins the next slot. Legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with its fields until accepted.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_stall  out  1  CPU request not accepted this cycle (combinational).
- cpu_rdata  out  DATA_WIDTH  CPU read data; meaningful only while cpu_rvalid is high.
- cpu_rvalid  out  1  one-cycle pulse marking CPU read data valid.
- dbg_req  in  1  debug access request; held with its fields until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  ADDR_WIDTH  debug word address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_ack  out  1  one-cycle pulse: debug request accepted this cycle (combinational).
- dbg_rdata  out  DATA_WIDTH  debug read data.
- dbg_rvalid  out  1  one-cycle pulse marking debug read data valid.
- ram_addr  out  ADDR_WIDTH  SPRAM ADDRESS.
- ram_wdata  out  DATA_WIDTH  SPRAM DATAIN.
- ram_we  out  1  SPRAM WREN.
- ram_maskwren  out  4  SPRAM MASKWREN; all four bits equal ram_we.
- ram_rdata  in  DATA_WIDTH  SPRAM DATAOUT.

Behaviour:
- **Grant decision** is combinational each cycle, from the requests and the burst counter:
  - Only cpu_req: CPU wins.
  - Only dbg_req: debug wins.
  - Both, with burst_cnt < MAX_CPU_BURST: CPU wins.
  - Both, with burst_cnt == MAX_CPU_BURST: debug wins.
- **Accept signals:**
  - cpu_stall = cpu_req & ~cpu_win.
  - dbg_ack = dbg_win.
  - Neither is asserted while reset is high.
- **Issue register:** at posedge of cycle N, the winner's {owner, we, addr, wdata} is captured with issue_valid = 1. If there is no winner, issue_valid = 0.
- **SPRAM port during cycle N+1:**
  - ram_addr and ram_wdata come from the issue register.
  - ram_we = issue_valid & issue_we.
  - With no valid issue, ram_we = 0 and address/data hold their last values.
- **Read return:**
  - An issued read (we = 0) is tracked in a return register at posedge end of N+1 (rd_valid, rd_owner).
  - In cycle N+2, the owner's rvalid is 1 and its rdata = ram_rdata.
  - The other owner's rvalid is 0 and its rdata is 0.
  - Writes produce no rvalid.
- **Throughput:** one access per cycle, back-to-back. Read latency is 2 cycles from acceptance to rvalid.
- **burst_cnt (8-bit):**
  - Increments on a CPU grant while dbg_req is high, saturating at MAX_CPU_BURST.
  - Clears on a debug grant, and on any cycle where dbg_req is low.
- **Ordering:** accesses complete in grant order. A debug write followed by a CPU read of the same address returns the new data.
- **Reset:**
  - Clears issue_valid, rd_valid and burst_cnt; ram_addr, ram_wdata and ram_we go to 0.
  - All outputs are 0 in the cycle after reset is sampled.
  - A read in flight when reset asserts is discarded; no rvalid follows.
  - Requests held across reset are re-arbitrated after reset deasserts.
- **Simultaneous events:** a new grant and a returning rvalid in the same cycle are independent and both occur.

Test Plan:
1. CPU-only write then read: write 0xBEEF to addr 0x0123 (cpu_stall = 0 both cycles), then read 0x0123 → cpu_rvalid high exactly 2 cycles after the read is accepted, with cpu_rdata = 0xBEEF; dbg_rvalid stays 0.
2. Debug-only read: dbg_req for addr 0x3FFF holding 0x1234 → dbg_ack for 1 cycle; dbg_rvalid with 0x1234 two cycles later.
3. Contention with starvation bound: cpu_req and dbg_req held continuously, MAX_CPU_BURST = 8 → 8 CPU grants, then dbg_ack with cpu_stall = 1 that cycle, then CPU grants resume and burst_cnt = 0.
4. Back-to-back interleaved reads: CPU reads A, debug reads B, CPU reads C on consecutive cycles → rvalids on consecutive cycles, each to the correct owner with the correct data.
5. Write-then-read ordering across owners: debug writes 0x5555 to 0x0010, and in the next cycle the CPU reads 0x0010 → cpu_rdata = 0x5555.
6. Reset mid-read: CPU read accepted, reset asserted the next cycle → no cpu_rvalid; all outputs 0; burst_cnt = 0; a held cpu_req is granted on the first cycle after reset deasserts.
